// File: rtl/bitsim_pkg.sv
// Shared widths and FSM state type for the essential-bit sequencer.
package bitsim_pkg;
    localparam int CNT_W = 4;
    localparam int OP_W  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;
endpackage

// File: rtl/lead_one_enc8.sv
// Leading-one encoder: index counted from the MSB (bit7 -> 0), plus an all-zero flag.
module lead_one_enc8
    import bitsim_pkg::*;
(
    input  logic [OP_W-1:0] mag,
    output logic [2:0]      idx,
    output logic            zero
);
    always_comb begin
        idx  = '0;
        zero = (mag == '0);
        // Ascending scan so the highest set bit is the last one to win.
        for (int i = 0; i < OP_W; i++) begin
            if (mag[i]) idx = 3'(OP_W - 1 - i);
        end
    end
endmodule

// File: rtl/essential_bit_sequencer.sv
// Emits one beat per set bit of an operand, MSB first, truncated to MAX_TERMS beats.
module essential_bit_sequencer
    import bitsim_pkg::*;
#(
    parameter int MAX_TERMS = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] in_mag,
    input  logic            in_sign,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      out_shift,
    output logic            out_sign,
    output logic            out_zero,
    output logic            out_last,
    output logic [CNT_W-1:0] out_idx
);
    seq_state_t       state;
    logic [OP_W-1:0]  residue;
    logic             sign_q;
    logic [CNT_W-1:0] cnt;

    logic [2:0] lead_idx;
    logic       lead_zero;
    logic       single_bit;
    logic       in_hs;
    logic       out_hs;

    lead_one_enc8 u_enc (
        .mag  (residue),
        .idx  (lead_idx),
        .zero (lead_zero)
    );

    // True for zero or exactly one set bit; zero is separately flagged.
    assign single_bit = ((residue & (residue - OP_W'(1))) == '0);

    assign out_valid = (state == RUN);
    assign out_shift = lead_idx;
    assign out_idx   = cnt;
    assign out_sign  = sign_q;
    assign out_zero  = out_valid & lead_zero;
    assign out_last  = out_valid & (single_bit | (cnt == CNT_W'(MAX_TERMS - 1)));

    assign out_hs   = out_valid & out_ready;
    assign in_ready = (state == IDLE) | (out_hs & out_last);
    assign in_hs    = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            residue <= '0;
            sign_q  <= 1'b0;
            cnt     <= '0;
        end else if (in_hs) begin
            // Covers both the idle accept and the no-bubble reload on a last beat.
            state   <= RUN;
            residue <= in_mag;
            sign_q  <= in_sign;
            cnt     <= '0;
        end else if (out_hs) begin
            if (out_last) begin
                state   <= IDLE;
                residue <= '0;
            end else begin
                residue <= residue & ~({1'b1, {(OP_W-1){1'b0}}} >> lead_idx);
                cnt     <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_essential_bit_sequencer.sv
// Scoreboard bench: driver queues expected beats per accepted operand, monitor checks them.
module tb_essential_bit_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, in_sign;
    logic [7:0] in_mag;
    logic       out_valid, out_ready, out_sign, out_zero, out_last;
    logic [2:0] out_shift;
    logic [3:0] out_idx;

    logic       v2, rdy2, s2, val2, ordy2, sgn2, zero2, last2;
    logic [7:0] m2;
    logic [2:0] shift2;
    logic [3:0] idx2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int shift;
        int idx;
        bit last;
        bit zero;
        bit sign;
    } beat_t;

    beat_t q[$];
    bit    mon_en = 0;
    bit    pend = 0;
    logic [7:0] pend_mag;
    bit    pend_sign;

    always #5 clk = ~clk;

    essential_bit_sequencer #(.MAX_TERMS(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_mag(in_mag), .in_sign(in_sign), .out_valid(out_valid), .out_ready(out_ready),
        .out_shift(out_shift), .out_sign(out_sign), .out_zero(out_zero),
        .out_last(out_last), .out_idx(out_idx)
    );

    essential_bit_sequencer #(.MAX_TERMS(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(v2), .in_ready(rdy2),
        .in_mag(m2), .in_sign(s2), .out_valid(val2), .out_ready(ordy2),
        .out_shift(shift2), .out_sign(sgn2), .out_zero(zero2),
        .out_last(last2), .out_idx(idx2)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: set bits taken MSB first, at most maxt of them; zero operand is one zero beat.
    function automatic void push_beats(input logic [7:0] m, input bit s, input int maxt);
        int shifts[$];
        beat_t b;
        if (m == 8'h00) begin
            b = '{shift: 0, idx: 0, last: 1, zero: 1, sign: s};
            q.push_back(b);
            return;
        end
        for (int bitpos = 7; bitpos >= 0; bitpos--)
            if (m[bitpos] && shifts.size() < maxt) shifts.push_back(7 - bitpos);
        for (int k = 0; k < shifts.size(); k++) begin
            b = '{shift: shifts[k], idx: k, last: (k == shifts.size() - 1), zero: 0, sign: s};
            q.push_back(b);
        end
    endfunction

    // One stimulus cycle: inputs change 1ns after the edge, acceptance judged at the falling edge.
    task automatic step(input bit v, input logic [7:0] m, input bit s, input bit ordy, input bit rst);
        @(posedge clk);
        #1;
        if (pend) begin
            push_beats(pend_mag, pend_sign, 8);
            pend = 0;
        end
        if (rst) q.delete();
        reset     = rst;
        in_valid  = v;
        in_mag    = m;
        in_sign   = s;
        out_ready = ordy;
        @(negedge clk);
        if (!rst && in_valid && in_ready) begin
            pend      = 1;
            pend_mag  = m;
            pend_sign = s;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            beat_t e;
            bit exp_rdy;
            chk("out_valid", int'(out_valid), int'(q.size() != 0));
            exp_rdy = (q.size() == 0);
            if (q.size() != 0 && out_ready && q[0].last) exp_rdy = 1;
            chk("in_ready", int'(in_ready), int'(exp_rdy));
            if (out_valid && q.size() != 0) begin
                e = q[0];
                chk("out_shift", int'(out_shift), e.shift);
                chk("out_idx",   int'(out_idx),   e.idx);
                chk("out_last",  int'(out_last),  int'(e.last));
                chk("out_zero",  int'(out_zero),  int'(e.zero));
                chk("out_sign",  int'(out_sign),  int'(e.sign));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        reset = 1; in_valid = 0; in_mag = 0; in_sign = 0; out_ready = 0;
        v2 = 0; m2 = 0; s2 = 0; ordy2 = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready",  int'(in_ready),  1);
        chk("rst_out_shift", int'(out_shift), 0);
        chk("rst_out_idx",   int'(out_idx),   0);
        chk("rst_out_sign",  int'(out_sign),  0);
        chk("rst_out_zero",  int'(out_zero),  0);
        chk("rst_out_last",  int'(out_last),  0);
        @(posedge clk); #1;
        reset  = 0;
        mon_en = 1;

        // Truncation with MAX_TERMS=2 on 8'hFF
        @(posedge clk); #1; v2 = 1; m2 = 8'hFF;
        @(negedge clk); chk("t2_in_ready", int'(rdy2), 1);
        @(posedge clk); #1; v2 = 0;
        @(negedge clk);
        chk("t2_b0_valid", int'(val2), 1);
        chk("t2_b0_shift", int'(shift2), 0);
        chk("t2_b0_idx",   int'(idx2), 0);
        chk("t2_b0_last",  int'(last2), 0);
        @(negedge clk);
        chk("t2_b1_valid", int'(val2), 1);
        chk("t2_b1_shift", int'(shift2), 1);
        chk("t2_b1_idx",   int'(idx2), 1);
        chk("t2_b1_last",  int'(last2), 1);
        @(negedge clk);
        chk("t2_idle_valid", int'(val2), 0);
        chk("t2_idle_ready", int'(rdy2), 1);

        // Directed: mixed bits, zero operand, stall, back-to-back, reset mid-operand
        step(1, 8'hA1, 1, 1, 0);
        repeat (4) step(0, 8'h00, 0, 1, 0);
        step(1, 8'h00, 0, 1, 0);
        repeat (3) step(0, 8'h00, 0, 1, 0);
        step(1, 8'h81, 0, 1, 0);
        repeat (3) step(0, 8'h00, 0, 0, 0);
        repeat (3) step(0, 8'h00, 0, 1, 0);
        step(1, 8'h80, 0, 1, 0);
        step(1, 8'h01, 1, 1, 0);
        repeat (3) step(0, 8'h00, 0, 1, 0);
        step(1, 8'hFF, 0, 1, 0);
        step(0, 8'h00, 0, 1, 0);
        step(0, 8'h00, 0, 1, 1);
        step(1, 8'h40, 0, 1, 0);
        repeat (3) step(0, 8'h00, 0, 1, 0);

        // Random traffic with occasional resets and single-bit/zero biased operands
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] m;
            int sel;
            sel = $urandom_range(0, 9);
            m = 8'($urandom);
            if (sel == 0) m = 8'h00;
            else if (sel == 1) m = 8'h01 << $urandom_range(0, 7);
            step(($urandom_range(0, 3) != 0), m, 1'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 199) == 0));
        end

        repeat (20) step(0, 8'h00, 0, 1, 0);
        chk("drained", q.size(), 0);
        mon_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/essential_bit_sequencer.md
ESSENTIAL_BIT_SEQUENCER -- requirements
Module: essential_bit_sequencer

Interface
REQ-001 SHALL have parameter MAX_TERMS, default 8, meaning the maximum number of output beats per operand (legal range 1..8).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  the reset: synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  an operand is offered.
REQ-005 SHALL have port in_ready  output  1  the block accepts the operand this cycle.
REQ-006 SHALL have port in_mag  input  8  the operand magnitude bitmask.
REQ-007 SHALL have port in_sign  input  1  the operand sign; passed through to every beat.
REQ-008 SHALL have port out_valid  output  1  a beat is presented.
REQ-009 SHALL have port out_ready  input  1  the consumer takes the beat.
REQ-010 SHALL have port out_shift  output  3  the leading-one index counted from the MSB (bit7 -> 0, bit0 -> 7).
REQ-011 SHALL have port out_sign  output  1  the latched in_sign.
REQ-012 SHALL have port out_zero  output  1  the operand was all-zero.
REQ-013 SHALL have port out_last  output  1  the final beat of this operand.
REQ-014 SHALL have port out_idx  output  4  the beat number within the operand, starting at 0.

Function
REQ-015 SHALL implement an FSM with two states: IDLE (no operand held) and RUN (residue register holds an operand).
REQ-016 SHALL define a handshake as valid&ready on the same cycle; the in-side and out-side handshakes are independent.
REQ-017 SHALL accept the operand in IDLE when in_valid=1 and in_ready=1: latch in_mag into the residue register, latch in_sign, clear the beat counter, go to RUN.
REQ-018 SHALL drive in_ready=1 in IDLE, and in RUN only on the cycle where out_valid&out_ready&out_last (back-to-back acceptance); in_ready=0 otherwise.
REQ-019 SHALL in RUN assert out_valid combinationally from state, with out_shift = the leading-one index of the residue and out_idx = the beat counter.
REQ-020 SHALL make the first beat visible the cycle after the input handshake (latency 1); one beat per cycle thereafter while out_ready=1.
REQ-021 SHALL on each non-last out handshake clear the emitted leading-one bit from the residue and increment the beat counter.
REQ-022 SHALL assert out_last when the residue has exactly one set bit, or when the beat counter equals MAX_TERMS-1 (truncation: remaining lower bits are discarded).
REQ-023 SHALL handle an all-zero operand as exactly one beat with out_zero=1, out_last=1, out_shift=0, out_idx=0; out_zero=0 on all other beats.
REQ-024 SHALL on the last-beat handshake go to IDLE, or, if an input handshake occurs on the same cycle, reload and stay in RUN with no bubble.
REQ-025 SHALL hold all out_* values stable while out_valid=1 and out_ready=0.
REQ-026 SHALL drive out_valid=0 in IDLE; the other out_* values are don't-care when out_valid=0 but SHALL be 0 after reset.

Reset
REQ-027 SHALL on reset=1 at a clock edge: state=IDLE, residue=0, sign=0, beat counter=0; reset takes priority over any handshake.
REQ-028 SHALL when reset is asserted mid-operand drop that operand without emitting further beats; in the cycle after reset, out_valid=0 and in_ready=1.

Structure
REQ-029 SHALL take the beat-counter width (4), the operand width (8) and the FSM state enum type from the shared package bitsim_pkg.
REQ-030 SHALL place the leading-one detection in one combinational sub-module, lead_one_enc8 (8-bit in, 3-bit index plus zero flag out); everything else is in this module.

Verification
REQ-031 SHALL cover: in_mag=8'b1010_0001, sign=1, out_ready=1 -> beats of (shift, idx, last) equal to (0,0,0), (2,1,0), (7,2,1), all with out_sign=1.
REQ-032 SHALL cover: in_mag=8'h00 -> a single beat with zero=1, last=1, shift=0, idx=0; in_ready=1 the following cycle.
REQ-033 SHALL cover: MAX_TERMS=2, in_mag=8'hFF -> beats shift 0 then shift 1 with last=1, then IDLE.
REQ-034 SHALL cover: in_mag=8'h81 with out_ready=0 for 3 cycles on beat 0 -> shift=0, idx=0 held stable, then shift 7 with last=1 once out_ready=1.
REQ-035 SHALL cover: 8'h80 then 8'h01 offered continuously -> 8'h01 accepted on the 8'h80 last-beat cycle; beats are shift 0 last, then shift 7 last on consecutive cycles.
REQ-036 SHALL cover: reset pulsed during beat 1 of 8'hFF -> next cycle out_valid=0 and in_ready=1; a new operand 8'h40 then yields one beat with shift=1, last=1.
